// File: rtl/unpooler.sv
// unpooler: streaming inverse of the pooling stage.
// Buffers one pooled row, then replays it as p upsampled rows.
module unpooler #(
   parameter int m     = 12,
   parameter int p     = 3,
   parameter int N     = 16,
   parameter int utype = 0
) (
   input  logic         clk,
   input  logic         master_rst,
   input  logic         ce,
   input  logic [N-1:0] data_in,
   input  logic         valid_ip,
   output logic         ready_ip,
   output logic [N-1:0] data_out,
   output logic         valid_op,
   output logic         end_op
);

   localparam int K  = m / p;
   localparam int KW = (K > 1) ? $clog2(K) : 1;
   localparam int CW = (m > 1) ? $clog2(m) : 1;
   localparam int PW = (p > 1) ? $clog2(p) : 1;

   localparam logic [KW-1:0] K_LAST = KW'(K - 1);
   localparam logic [CW-1:0] C_LAST = CW'(m - 1);
   localparam logic [PW-1:0] P_LAST = PW'(p - 1);

   typedef enum logic {FILL, EMIT} state_t;

   state_t        state_q;
   state_t        state_nx;

   logic [KW-1:0] wr_idx;
   logic [CW-1:0] col;
   logic [PW-1:0] rrep;
   logic [KW-1:0] prow;
   logic [PW-1:0] wcol;
   logic [KW-1:0] bidx;

   logic [N-1:0]  lbuf [K];

   logic          accept;
   logic          emit;
   logic          wr_last;
   logic          col_last;
   logic          rep_last;
   logic          win_last;
   logic          row_done;
   logic          map_done;
   logic [N-1:0]  pix;

   // Handshake and position decode shared by the state and datapath logic.
   always_comb begin
      accept   = ce && valid_ip && ready_ip && (state_q == FILL);
      emit     = ce && (state_q == EMIT);
      wr_last  = (wr_idx == K_LAST);
      col_last = (col == C_LAST);
      rep_last = (rrep == P_LAST);
      win_last = (wcol == P_LAST);
      row_done = col_last && rep_last;
      map_done = row_done && (prow == K_LAST);
   end

   // State register.
   always_ff @(posedge clk or negedge master_rst) begin
      if (!master_rst) begin
         state_q <= FILL;
      end else if (ce) begin
         state_q <= state_nx;
      end
   end

   // Next state: a full row moves to EMIT, the last replicated pixel returns.
   always_comb begin
      state_nx = state_q;
      unique case (state_q)
         FILL: if (accept && wr_last) state_nx = EMIT;
         EMIT: if (row_done) state_nx = FILL;
         default: state_nx = FILL;
      endcase
   end

   // Pixel value: zero-insert keeps only each window's top-left corner.
   always_comb begin
      pix = '0;
      if (utype == 0 || (wcol == '0 && rrep == '0)) begin
         pix = lbuf[bidx];
      end
   end

   // Line buffer holds one pooled row; contents need no reset.
   always_ff @(posedge clk) begin
      if (accept) begin
         lbuf[wr_idx] <= data_in;
      end
   end

   // Write index plus raster counters; wcol/bidx stand in for col%p, col/p.
   always_ff @(posedge clk or negedge master_rst) begin
      if (!master_rst) begin
         wr_idx <= '0;
         col    <= '0;
         rrep   <= '0;
         prow   <= '0;
         wcol   <= '0;
         bidx   <= '0;
      end else if (accept) begin
         wr_idx <= wr_last ? '0 : wr_idx + KW'(1);
      end else if (emit) begin
         col  <= col_last ? '0 : col + CW'(1);
         wcol <= (win_last || col_last) ? '0 : wcol + PW'(1);
         if (col_last) begin
            bidx <= '0;
         end else if (win_last) begin
            bidx <= bidx + KW'(1);
         end
         if (col_last) begin
            rrep <= rep_last ? '0 : rrep + PW'(1);
         end
         if (row_done) begin
            prow <= (prow == K_LAST) ? '0 : prow + KW'(1);
         end
      end
   end

   // Registered outputs; valid/end drop on any edge that emits nothing.
   always_ff @(posedge clk or negedge master_rst) begin
      if (!master_rst) begin
         data_out <= '0;
         valid_op <= 1'b0;
         end_op   <= 1'b0;
         ready_ip <= 1'b1;
      end else begin
         valid_op <= emit;
         end_op   <= emit && map_done;
         if (emit) begin
            data_out <= pix;
         end
         if (accept && wr_last) begin
            ready_ip <= 1'b0;
         end else if (emit && row_done) begin
            ready_ip <= 1'b1;
         end
      end
   end

endmodule

// File: doc/unpooler.md
# unpooler

Streaming upsampler that performs the inverse of the pooling stage. It accepts a pooled feature map of (m/p)×(m/p) fixed-point values in raster order and emits an m×m map in raster order, one pixel per enabled cycle. Each pooled value either fills its p×p window (nearest-neighbour) or is placed at the window's top-left corner with zeros elsewhere (zero-insert unpooling). The block sits in decoder/upsampling paths, between a pooled-map producer and downstream convolution stages.

## Interface
- m, 12: output map side length; must be an integer multiple of p.
- p, 3: window side length / upsampling factor; p ≥ 1.
- N, 16: data word width; fixed-point format is passed through unchanged.
- utype, 0: 0 = nearest-neighbour replicate, 1 = zero-insert.
- clk  in  1  single clock, rising edge.
- master_rst  in  1  asynchronous, active-low reset.
- ce  in  1  clock enable; when low, all state, counters and registers hold.
- data_in  in  N  pooled input value.
- valid_ip  in  1  data_in is valid.
- ready_ip  out  1  block can accept input (registered).
- data_out  out  N  upsampled output pixel (registered).
- valid_op  out  1  data_out is valid this cycle (registered).
- end_op  out  1  one-cycle pulse with the last pixel of the m×m map (registered).

## Operation
- k = m/p. A k-entry line buffer holds one pooled row. The buffer is not reset.
- Counters: wr_idx 0..k-1, col 0..m-1, rrep 0..p-1, prow 0..k-1.
- Two states. The reset state is FILL.
- FILL: ready_ip = 1. When ce && valid_ip && ready_ip, write data_in to buf[wr_idx] and increment wr_idx. Gaps in valid_ip are allowed. On the accept with wr_idx = k-1: clear wr_idx, go to EMIT, and drop ready_ip on the same edge.
- EMIT: on each ce cycle, register one pixel at (rrep, col), then advance col.
  - utype 0: data_out <= buf[col/p].
  - utype 1: data_out <= buf[col/p] when col%p == 0 and rrep == 0; otherwise 0.
  - When col wraps at m-1, increment rrep.
  - When rrep wraps at p-1 (last pixel of the p-th replicated row): increment prow, go to FILL, and assert ready_ip on that edge.
  - When that last pixel is also in prow = k-1, i.e. pixel (m-1, m-1): assert end_op with it, then clear prow.
- The next pooled row can only be accepted after the current row's p output rows are finished. There is no overlap of FILL and EMIT.
- Division and modulo by p are implemented as small sub-counters (a within-window column counter and a buffer index), not dividers.

## Timing
- Reset (asynchronous assert): data_out = 0, valid_op = 0, end_op = 0, ready_ip = 1. State = FILL, all counters = 0. Reset takes effect immediately, including mid-EMIT. A partially filled or emitted row is discarded.
- valid_op and end_op are low in any cycle where no pixel was registered on the preceding edge: FILL, or ce low. data_out holds its last value.
- Latency: the first pixel of a row is registered on the first ce edge after the edge that accepted the k-th input. With ce held high, valid_op rises one cycle after the final accept.
- Throughput with ce held high: p·m output cycles plus at least k input cycles per pooled row.
- ce low in EMIT: no pixel is emitted and the counters freeze. Output resumes at the same (rrep, col).
- valid_ip asserted while ready_ip = 0: ignored, no write.
- p = 1: a pure pass-through that re-times each row of m values. Both utype settings give identical output.

## Test plan
- Nearest-neighbour, m=12, p=3, utype 0, ce=1: feed 1..16 with valid_ip held high.
  - Expect 144 valid outputs.
  - Rows 0–2 each read 1,1,1,2,2,2,3,3,3,4,4,4; rows 3–5 use 5..8; rows 9–11 use 13..16.
  - end_op is high only with the 144th pixel.
- Zero-insert, m=12, p=3, utype 1: feed 1..16.
  - Row 0 reads 1,0,0,2,0,0,3,0,0,4,0,0; rows 1–2 are all 0; row 3 starts with 5.
  - Output contains exactly 16 non-zero pixels.
- Handshake: valid_ip toggles 1/0 during FILL.
  - Only cycles with valid_ip high are written.
  - ready_ip is low for exactly 36 ce cycles per pooled row.
  - Inputs presented while ready_ip is low are dropped; check with a value of 0xFFFF.
- ce gating: ce=0 for 5 cycles mid-row during EMIT.
  - valid_op stays low for those 5 cycles.
  - The sequence resumes with no skipped or repeated pixel; the total count stays 144.
- Reset mid-EMIT: pull master_rst low at output pixel 50.
  - All outputs go to 0 asynchronously and ready_ip goes to 1.
  - A fresh feed of 1..16 reproduces the first test exactly.
- Back-to-back maps: two maps of 16 inputs each (1..16, then 101..116).
  - Expect two end_op pulses, 144 pixels apart.
  - The first pixel of the second map is 101.
